mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Initiator side of the data-RAM port: turns single load/store requests from the core into correctly timed `addr`/`write`/`value` cycles on the RAM and returns `result`.
- The RAM commits writes on the falling clock edge and reads combinationally. This block holds each access stable for one full clock and samples read data on the following rising edge.
- Enforces the memory map: words 0..2 are display registers, word 3 is the read-only switch port, words 4..MAX_ADDR are general data.
- Sits between the core's load/store stage and the RAM.

Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 32, data width
- MAX_ADDR, 10, highest implemented word address
- RO_ADDR, 3, read-only switch-input address; writes are rejected

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  response available
- rsp_ready  in  1  core consumes response
- rsp_data  out  DATA_W  load data, or store readback
- rsp_err  out  1  request rejected, no RAM access performed
- ram_addr  out  ADDR_W  to RAM `addr`
- ram_write  out  1  to RAM `write`
- ram_value  out  DATA_W  to RAM `value`
- ram_result  in  DATA_W  from RAM `result`

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0.
  - ram_addr=0, ram_write=0, ram_value=0.
  - Reset mid-access aborts the access. ram_write is low in the very next cycle, so no write commits at the following falling edge.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, register write/addr/wdata.
  - Valid request: go to ACCESS.
  - Invalid request: go to RESP with rsp_err=1, rsp_data=0; RAM is untouched.
  - Invalid means req_addr > MAX_ADDR, or req_write with req_addr == RO_ADDR.
- ACCESS (exactly one cycle):
  - ram_addr and ram_value driven from the registered request; ram_write = registered write.
  - The RAM commits a write at the mid-cycle falling edge.
  - At the closing rising edge: rsp_data <= ram_result, rsp_err=0, go to RESP. For a store, rsp_data is the post-write readback.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready is sampled high, then go to IDLE.
  - req_ready=0 in ACCESS and RESP. There is no overlap; the next request is accepted the cycle after the response handshake.
- ram_write=1 only in ACCESS with a store. ram_addr and ram_value hold their last values outside ACCESS.
- Latency, from accept edge N:
  - valid access: rsp_valid at N+2.
  - rejected request: rsp_valid at N+1.
- A load of RO_ADDR returns the switch value zero-extended by the RAM; the block passes it through unmodified.
- Address MAX_ADDR is valid; MAX_ADDR+1 and above are rejected.

Optional Feature:
- Macro: MEM_MASTER_PERF_EN.
- Defined:
  - Adds outputs cnt_rd, cnt_wr, cnt_err, each 16 bits.
  - cnt_rd / cnt_wr increment at the ACCESS exit edge for loads / stores.
  - cnt_err increments on entering RESP with rsp_err=1.
  - All counters are cleared by reset and saturate at 16'hFFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mem_map_pkg holds:
  - state encoding (IDLE=0, ACCESS=1, RESP=2);
  - address constants DISP1_ADDR=0, DISP2_ADDR=1, DISP3_ADDR=2, SWITCH_ADDR=3, MAX_ADDR=10.
- One natural sub-module: mem_addr_check, combinational. Inputs addr and write; outputs valid and ro_violation. It is reused later by the fetch/debug port.

Test Plan:
- Store 32'h0000007F to addr 0 with rsp_ready=1:
  - ram_write high for exactly one cycle, at N+1;
  - rsp_valid at N+2 with rsp_data=32'h7F, rsp_err=0;
  - a following load of addr 0 returns 32'h7F.
- Switch input=18'h2A5A5, load addr 3 -> rsp_data=32'h0002A5A5.
- Store to addr 3 and store to addr 11:
  - ram_write never asserted;
  - rsp_valid at N+1 with rsp_err=1, rsp_data=0.
- Load addr 10 after storing 32'hDEADBEEF there -> rsp_data=32'hDEADBEEF, no error.
- rsp_ready held low 5 cycles after a load -> rsp_valid, rsp_data and rsp_err stable for all 5 cycles; req_ready=0 throughout; a new req_valid is ignored until the handshake completes.
- reset asserted during ACCESS of a store to addr 5:
  - next cycle ram_write=0 and all outputs at reset values;
  - with MEM_MASTER_PERF_EN, counters read 0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the data-RAM initiator and related ports.
// Holds the access FSM state encoding and the fixed word addresses of the map.
package mem_map_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DISP1_ADDR  = 0;
  localparam int DISP2_ADDR  = 1;
  localparam int DISP3_ADDR  = 2;
  localparam int SWITCH_ADDR = 3;
  localparam int MAX_ADDR    = 10;

  localparam int CNT_W = 16;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational memory-map check: is the word implemented, and is it a store
// to the read-only switch port. Shared with the fetch/debug port.
module mem_addr_check
  import mem_map_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int MAX_ADDR = mem_map_pkg::MAX_ADDR,
  parameter int RO_ADDR  = SWITCH_ADDR
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  output logic              valid,
  output logic              ro_violation
);

  always_comb begin
    valid        = (addr <= ADDR_W'(MAX_ADDR));
    ro_violation = write && (addr == ADDR_W'(RO_ADDR));
  end

endmodule

// File: rtl/mem_master.sv
// Data-RAM initiator: turns single core load/store requests into one-cycle RAM
// accesses. Optional access counters are built when MEM_MASTER_PERF_EN is defined.
module mem_master
  import mem_map_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_ADDR = mem_map_pkg::MAX_ADDR,
  parameter int RO_ADDR  = SWITCH_ADDR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_value,
  input  logic [DATA_W-1:0] ram_result
`ifdef MEM_MASTER_PERF_EN
  ,
  output logic [CNT_W-1:0]  cnt_rd,
  output logic [CNT_W-1:0]  cnt_wr,
  output logic [CNT_W-1:0]  cnt_err
`endif
);

  state_t state;
  logic   addr_ok;
  logic   ro_violation;
  logic   req_ok;

  mem_addr_check #(
    .ADDR_W  (ADDR_W),
    .MAX_ADDR(MAX_ADDR),
    .RO_ADDR (RO_ADDR)
  ) u_addr_check (
    .addr        (req_addr),
    .write       (req_write),
    .valid       (addr_ok),
    .ro_violation(ro_violation)
  );

  assign req_ok = addr_ok && !ro_violation;

  // The ram_* registers double as the captured request, so the RAM sees a
  // stable access for the whole ACCESS cycle, including the falling-edge commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      ram_addr  <= '0;
      ram_write <= 1'b0;
      ram_value <= '0;
`ifdef MEM_MASTER_PERF_EN
      cnt_rd    <= '0;
      cnt_wr    <= '0;
      cnt_err   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_ok) begin
              ram_addr  <= req_addr;
              ram_value <= req_wdata;
              ram_write <= req_write;
              state     <= ACCESS;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= RESP;
`ifdef MEM_MASTER_PERF_EN
              if (cnt_err != '1) cnt_err <= cnt_err + 1'b1;
`endif
            end
          end
        end
        ACCESS: begin
          ram_write <= 1'b0;
          rsp_data  <= ram_result;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
`ifdef MEM_MASTER_PERF_EN
          if (ram_write) begin
            if (cnt_wr != '1) cnt_wr <= cnt_wr + 1'b1;
          end else begin
            if (cnt_rd != '1) cnt_rd <= cnt_rd + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          ram_write <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed testbench for mem_master with a behavioural RAM that commits on the
// falling edge and reads combinationally; word 3 returns an 18-bit switch value.
module tb_mem_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [9:0]  ram_addr;
  logic        ram_write;
  logic [31:0] ram_value;
  logic [31:0] ram_result;
`ifdef MEM_MASTER_PERF_EN
  logic [15:0] cnt_rd;
  logic [15:0] cnt_wr;
  logic [15:0] cnt_err;
`endif

  logic [31:0] ram_mem [0:10] = '{default: 32'h0};
  logic [17:0] switches = 18'h2A5A5;
  int          write_cycles = 0;
  int          pass_count = 0;
  int          fail_count = 0;
  int          total_count = 0;
  int          write_mark;

  mem_master dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ram_addr  (ram_addr),
    .ram_write (ram_write),
    .ram_value (ram_value),
    .ram_result(ram_result)
`ifdef MEM_MASTER_PERF_EN
    ,
    .cnt_rd    (cnt_rd),
    .cnt_wr    (cnt_wr),
    .cnt_err   (cnt_err)
`endif
  );

  always #5 clock = ~clock;

  // RAM model: writes land on the falling edge; word 3 is the switch port.
  always @(negedge clock) begin
    if (ram_write === 1'b1) begin
      write_cycles <= write_cycles + 1;
      if (ram_addr <= 10'd10 && ram_addr != 10'd3) ram_mem[ram_addr] <= ram_value;
    end
  end

  always_comb begin
    ram_result = 32'h0;
    if (ram_addr == 10'd3) ram_result = {14'h0, switches};
    else if (ram_addr <= 10'd10) ram_result = ram_mem[ram_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Presents one request for a single edge; returns #1 after the accept edge.
  task automatic apply_stimulus(input logic write, input logic [9:0] addr,
                                input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    next_cycle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 10'h0;
    req_wdata = 32'h0;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 10'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    check_output("reset_req_ready", 32'(req_ready), 32'd1);
    check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_rsp_err",   32'(rsp_err),   32'd0);
    check_output("reset_rsp_data",  rsp_data,       32'h0);
    check_output("reset_ram_addr",  32'(ram_addr),  32'd0);
    check_output("reset_ram_write", 32'(ram_write), 32'd0);
    check_output("reset_ram_value", ram_value,      32'h0);
    reset = 1'b1;
    next_cycle();

    $display("[TB] store 0x7F to word 0");
    write_mark = write_cycles;
    apply_stimulus(1'b1, 10'd0, 32'h0000007F);
    check_output("st0_ram_write_n1", 32'(ram_write), 32'd1);
    check_output("st0_ram_value",    ram_value,      32'h7F);
    check_output("st0_req_ready",    32'(req_ready), 32'd0);
    check_output("st0_rsp_valid_n1", 32'(rsp_valid), 32'd0);
    next_cycle();
    check_output("st0_ram_write_n2", 32'(ram_write), 32'd0);
    check_output("st0_rsp_valid_n2", 32'(rsp_valid), 32'd1);
    check_output("st0_rsp_data",     rsp_data,       32'h7F);
    check_output("st0_rsp_err",      32'(rsp_err),   32'd0);
    next_cycle();
    check_output("st0_rsp_done",     32'(rsp_valid), 32'd0);
    check_output("st0_ready_again",  32'(req_ready), 32'd1);
    check_output("st0_write_cycles", 32'(write_cycles - write_mark), 32'd1);

    $display("[TB] load word 0 and switch word 3");
    apply_stimulus(1'b0, 10'd0, 32'h0);
    check_output("ld0_ram_write", 32'(ram_write), 32'd0);
    next_cycle();
    check_output("ld0_rsp_data", rsp_data, 32'h7F);
    check_output("ld0_rsp_err",  32'(rsp_err), 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 10'd3, 32'h0);
    next_cycle();
    check_output("ld3_rsp_data", rsp_data, 32'h0002A5A5);
    next_cycle();

    $display("[TB] rejected stores to words 3 and 11");
    write_mark = write_cycles;
    apply_stimulus(1'b1, 10'd3, 32'h12345678);
    check_output("st3_rsp_valid", 32'(rsp_valid), 32'd1);
    check_output("st3_rsp_err",   32'(rsp_err),   32'd1);
    check_output("st3_rsp_data",  rsp_data,       32'h0);
    check_output("st3_ram_write", 32'(ram_write), 32'd0);
    next_cycle();
    check_output("st3_done",      32'(rsp_valid), 32'd0);
    apply_stimulus(1'b1, 10'd11, 32'h87654321);
    check_output("st11_rsp_valid", 32'(rsp_valid), 32'd1);
    check_output("st11_rsp_err",   32'(rsp_err),   32'd1);
    check_output("st11_rsp_data",  rsp_data,       32'h0);
    next_cycle();
    check_output("reject_no_writes", 32'(write_cycles - write_mark), 32'd0);

    $display("[TB] store/load top word 10");
    apply_stimulus(1'b1, 10'd10, 32'hDEADBEEF);
    next_cycle();
    check_output("st10_rsp_err",  32'(rsp_err), 32'd0);
    check_output("st10_readback", rsp_data,     32'hDEADBEEF);
    next_cycle();
    apply_stimulus(1'b0, 10'd10, 32'h0);
    next_cycle();
    check_output("ld10_rsp_data", rsp_data,     32'hDEADBEEF);
    check_output("ld10_rsp_err",  32'(rsp_err), 32'd0);
    next_cycle();

    $display("[TB] response stall with competing request");
    rsp_ready = 1'b0;
    apply_stimulus(1'b0, 10'd10, 32'h0);
    next_cycle();
    write_mark = write_cycles;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 10'd4;
    req_wdata = 32'h00001234;
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      check_output($sformatf("stall%0d_rsp_data", i),  rsp_data,       32'hDEADBEEF);
      check_output($sformatf("stall%0d_rsp_err", i),   32'(rsp_err),   32'd0);
      check_output($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'd0);
      next_cycle();
    end
    rsp_ready = 1'b1;
    next_cycle();
    req_valid = 1'b0;
    req_write = 1'b0;
    check_output("stall_rsp_done",   32'(rsp_valid), 32'd0);
    check_output("stall_req_ready",  32'(req_ready), 32'd1);
    check_output("stall_no_write",   32'(write_cycles - write_mark), 32'd0);
    check_output("stall_word4_kept", ram_mem[4], 32'h0);
    next_cycle();

`ifdef MEM_MASTER_PERF_EN
    check_output("perf_cnt_rd",  32'(cnt_rd),  32'd4);
    check_output("perf_cnt_wr",  32'(cnt_wr),  32'd2);
    check_output("perf_cnt_err", 32'(cnt_err), 32'd2);
`endif

    $display("[TB] reset during store access");
    apply_stimulus(1'b1, 10'd5, 32'hCAFEF00D);
    check_output("rst_access_write", 32'(ram_write), 32'd1);
    reset = 1'b0;
    next_cycle();
    check_output("rst_ram_write", 32'(ram_write), 32'd0);
    check_output("rst_ram_addr",  32'(ram_addr),  32'd0);
    check_output("rst_ram_value", ram_value,      32'h0);
    check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("rst_rsp_data",  rsp_data,       32'h0);
    check_output("rst_rsp_err",   32'(rsp_err),   32'd0);
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
`ifdef MEM_MASTER_PERF_EN
    check_output("rst_cnt_rd",  32'(cnt_rd),  32'd0);
    check_output("rst_cnt_wr",  32'(cnt_wr),  32'd0);
    check_output("rst_cnt_err", 32'(cnt_err), 32'd0);
`endif
    reset = 1'b1;
    next_cycle();
    apply_stimulus(1'b0, 10'd10, 32'h0);
    next_cycle();
    check_output("post_rst_ld10", rsp_data, 32'hDEADBEEF);
    next_cycle();

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
